midi_encoder: RTL and testbench
===============================

# midi_encoder

Serializes MIDI channel and system messages onto a 31250-baud 8N1 UART line. It is the transmit-side counterpart of the MIDI decoder and sits between a message source (sequencer, controller echo, test pattern) and the MIDI OUT pin. It accepts one message per valid/ready handshake and emits 1, 2 or 3 bytes. Optional running status suppresses repeated status bytes.

## Interface
- `CLKS_PER_BIT`, 1600, clocks per UART bit (50 MHz / 31250); must be ≥ 2.
- `RUNNING_STATUS`, 1, 1 = omit a channel status byte equal to the last one sent.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `msg_valid`  in  1  message present on `msg_*`.
- `msg_ready`  out  1  encoder can accept a message this cycle.
- `msg_status`  in  8  status byte.
- `msg_data1`  in  8  first data byte; bit 7 ignored.
- `msg_data2`  in  8  second data byte; bit 7 ignored.
- `midi_tx`  out  1  serial line, idle high.
- `busy`  out  1  a message is in flight.
- `byte_done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `err_drop`  out  1  one-cycle pulse when a message is dropped.

## Operation
- Handshake: a message is accepted on a rising edge where `msg_valid && msg_ready`. Inputs are captured at that edge. `msg_valid` is ignored while `reset` is high.
- Message length is decoded from `msg_status`:
  - 0x80–0xBF and 0xE0–0xEF: 3 bytes.
  - 0xC0–0xDF: 2 bytes.
  - 0xF0–0xFF: 1 byte (status only).
  - Below 0x80: dropped. `err_drop` pulses on the accept edge, nothing is transmitted, and running status is unchanged.
- Data bytes are sent as {1'b0, data[6:0]}.
- Running status register `last_status` (8 bits plus a valid flag):
  - Updated by every accepted channel message (0x80–0xEF).
  - Cleared by 0xF0–0xF7.
  - Untouched by 0xF8–0xFF.
  - When `RUNNING_STATUS`=1, the status byte is valid, and it equals `msg_status`, only the data bytes are sent.
- Byte frame: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit is held for exactly `CLKS_PER_BIT` clocks.
- FSM states:
  - IDLE: `midi_tx`=1. On accept, go to START with the first byte loaded, or stay in IDLE on a drop.
  - START: go to DATA after `CLKS_PER_BIT` clocks.
  - DATA: go to STOP after 8 bits.
  - STOP: after `CLKS_PER_BIT` clocks, go to START if bytes remain, else IDLE.
- Bytes within one message are gapless.
- `busy` = (state != IDLE).

## Timing
- Reset values: `midi_tx`=1, `msg_ready`=1, `busy`=0, `byte_done`=0, `err_drop`=0, FSM in IDLE, running status invalid.
- All outputs are registered except `msg_ready`. `msg_ready` = IDLE, or (STOP and last bit-clock of the last byte).
- Latency: `midi_tx` falls at the accept edge E0, so the start bit begins in the cycle after E0.
- An n-byte transmission occupies exactly n·10·`CLKS_PER_BIT` clocks.
- A message accepted on the final stop-bit cycle starts its start bit with zero idle gap.
- `byte_done` is high during the last clock of every stop bit.
- Reset asserted mid-frame: `midi_tx` returns high immediately, the in-flight message is discarded, and running status is cleared.

## Structure
- `midi_pkg` holds:
  - Status nibble constants: NOTE_OFF 4'h8, NOTE_ON 4'h9, POLY_AT 4'hA, CC 4'hB, PROG 4'hC, CHAN_AT 4'hD, PITCH 4'hE, SYS 4'hF.
  - Function `midi_msg_len(status)` returning 0–3.
  - The default `CLKS_PER_BIT`.
  - The decoder and this block both use the package.
- Sub-module `uart_tx_8n1`: byte serializer with `start`/`byte`/`done`, bit counter and baud counter.
- `midi_encoder` keeps the message sequencer, running-status logic and handshake.

## Test plan
(all with `CLKS_PER_BIT`=4)
- Note on {0x90,0x3C,0x64} → line carries 0x90, 0x3C, 0x64 LSB-first in 120 clocks. `byte_done` pulses 3 times. `msg_ready` is high on clock 120.
- Back-to-back {0x90,0x3C,0x64} then {0x90,0x40,0x00} with `RUNNING_STATUS`=1 → second message sends only 0x40 and 0x00 (80 clocks), with no idle cycle between messages.
- Program change {0xC5,0x8A,x} → bytes 0xC5 then 0x0A; total 80 clocks.
- 0xF8 issued between two 0x90 note-ons → the second note-on omits its status. A 0xF0 issued instead forces 0x90 to be resent.
- Status 0x3C → `err_drop` pulses for 1 clock, `midi_tx` stays high, `busy` stays 0.
- Reset asserted at clock 15 of a note-on → `midi_tx`=1 immediately. After release, {0x90,…} is resent with the full status byte.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status constants, message-length decode and UART FSM states
package midi_pkg;
  localparam int MIDI_CLKS_PER_BIT = 1600;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [3:0] SYS      = 4'hF;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    return !status[7] ? 2'd0 :
           status[7:4] == SYS ? 2'd1 :
           (status[7:4] == PROG || status[7:4] == CHAN_AT) ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 byte serializer; a new byte may be loaded on the last stop-bit clock for gapless output
module uart_tx_8n1 import midi_pkg::*; #(
  parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       done,
  output logic       ready,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);
  tx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bitn;
  logic [7:0] sh;
  logic bit_end;
  assign bit_end = cnt == LAST;
  assign ready = state == IDLE || (state == STOP && bit_end);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bitn <= '0;
      sh <= '0;
      tx <= 1'b1;
      done <= 1'b0;
    end else begin
      done <= state == STOP && cnt == PRE;
      if (start && ready) begin
        state <= START;
        cnt <= '0;
        sh <= tx_byte;
        tx <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
        if (bit_end && state == START) begin
          state <= DATA;
          bitn <= '0;
          tx <= sh[0];
        end else if (bit_end && state == DATA) begin
          sh <= sh >> 1;
          bitn <= bitn + 1'b1;
          tx <= bitn == 3'd7 ? 1'b1 : sh[1];
          if (bitn == 3'd7) state <= STOP;
        end else if (bit_end) begin
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: rtl/midi_encoder.sv
// midi_encoder: sequences 1-3 byte MIDI messages with running status onto a 31250-baud 8N1 line
module midi_encoder import midi_pkg::*; #(
  parameter int CLKS_PER_BIT   = MIDI_CLKS_PER_BIT,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [7:0] msg_status,
  input  logic [7:0] msg_data1,
  input  logic [7:0] msg_data2,
  output logic       midi_tx,
  output logic       busy,
  output logic       byte_done,
  output logic       err_drop
);
  logic [7:0] p1, p2, rs, d1, d2, tx_byte;
  logic [1:0] rem, len;
  logic rs_valid, accept, skip, start, uart_ready;
  assign d1 = msg_data1 & 8'h7F;
  assign d2 = msg_data2 & 8'h7F;
  assign len = midi_msg_len(msg_status);
  assign msg_ready = uart_ready && rem == 2'd0;
  assign accept = msg_valid && msg_ready;
  // rs only ever holds channel statuses, so a match implies a channel message
  assign skip = RUNNING_STATUS && rs_valid && rs == msg_status;
  assign start = accept ? len != 2'd0 : rem != 2'd0;
  assign tx_byte = accept ? (skip ? d1 : msg_status) : p1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1 <= '0;
      p2 <= '0;
      rem <= '0;
      rs <= '0;
      rs_valid <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      err_drop <= accept && len == 2'd0;
      if (accept && len != 2'd0) begin
        p1 <= skip ? d2 : d1;
        p2 <= d2;
        rem <= len - 2'd1 - {1'b0, skip};
        if (msg_status < 8'hF0) begin
          rs <= msg_status;
          rs_valid <= 1'b1;
        end else if (msg_status < 8'hF8) begin
          rs_valid <= 1'b0;
        end
      end else if (uart_ready && rem != 2'd0) begin
        p1 <= p2;
        rem <= rem - 2'd1;
      end
    end
  end
  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk),
    .reset(reset),
    .start(start),
    .tx_byte(tx_byte),
    .tx(midi_tx),
    .done(byte_done),
    .ready(uart_ready),
    .busy(busy)
  );
endmodule

// File: tb/tb_midi_encoder.sv
// tb_midi_encoder: scoreboard bench with a line-level receiver monitor and a message-level reference model
module tb_midi_encoder;
  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;
  logic clk = 1'b0, reset = 1'b1, msg_valid = 1'b0;
  logic [7:0] msg_status = '0, msg_data1 = '0, msg_data2 = '0;
  logic msg_ready, midi_tx, busy, byte_done, err_drop;
  typedef struct {logic [7:0] b; bit first; bit last; int acc;} exp_t;
  exp_t q[$];
  int cyc = 0, tests = 0, fails = 0, last_rs = -1, drop_at = -1;

  midi_encoder #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .midi_tx(midi_tx), .busy(busy), .byte_done(byte_done), .err_drop(err_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: what bytes a message should produce, given the running status seen so far
  task automatic model(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b, input int acc);
    logic [7:0] bytes[$];
    bytes = {};
    if (s < 8'h80) begin
      drop_at = acc + 1;
      return;
    end
    bytes.push_back(s);
    if (s < 8'hF0) bytes.push_back(a & 8'h7F);
    if (s < 8'hC0 || (s >= 8'hE0 && s < 8'hF0)) bytes.push_back(b & 8'h7F);
    if (s < 8'hF0 && last_rs == int'(s)) void'(bytes.pop_front());
    if (s < 8'hF0) last_rs = int'(s);
    else if (s < 8'hF8) last_rs = -1;
    foreach (bytes[i]) q.push_back('{bytes[i], i == 0, i == bytes.size() - 1, acc});
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b, output int acc);
    int n;
    n = 0;
    acc = -1;
    msg_status = s;
    msg_data1 = a;
    msg_data2 = b;
    msg_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!msg_ready && n < 3000);
    if (!msg_ready) begin
      chk("accept_timeout", 0, 1);
      msg_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    model(s, a, b, acc);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(n < 5000), 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: receives frames off the line and checks every cycle against the scoreboard
  initial begin
    exp_t cur;
    bit frame, ferr;
    int idx, k, prev_end;
    logic [7:0] rx;
    logic e;
    frame = 0; ferr = 0; idx = 0; k = 0; prev_end = -100; rx = '0;
    cur = '{8'h00, 1'b0, 1'b1, 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        frame = 0;
        chk("reset_tx", int'(midi_tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_byte_done", int'(byte_done), 0);
        chk("reset_err_drop", int'(err_drop), 0);
        chk("reset_msg_ready", int'(msg_ready), 1);
        continue;
      end
      chk("err_drop", int'(err_drop), int'(cyc == drop_at));
      if (!frame && !midi_tx) begin
        frame = 1; idx = 0; ferr = 0; rx = '0;
        if (q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          cur = '{8'h00, 1'b0, 1'b1, 0};
        end else begin
          cur = q.pop_front();
          if (cur.first) chk("accept_latency", cyc, cur.acc + 1);
          else chk("byte_gap", cyc, prev_end + 1);
        end
      end
      if (frame) begin
        k = idx / CPB;
        e = k == 0 ? 1'b0 : k == 9 ? 1'b1 : cur.b[k-1];
        if (midi_tx !== e) ferr = 1;
        if (idx % CPB == CPB / 2 && k >= 1 && k <= 8) rx[k-1] = midi_tx;
        chk("busy", int'(busy), 1);
        chk("byte_done", int'(byte_done), int'(idx == FRAME - 1));
        chk("msg_ready", int'(msg_ready), int'(idx == FRAME - 1 && cur.last));
        if (idx == FRAME - 1) begin
          chk("frame", int'({ferr, rx}), int'({1'b0, cur.b}));
          frame = 0;
          prev_end = cyc;
        end else idx++;
      end else begin
        chk("idle_busy", int'(busy), 0);
        chk("idle_byte_done", int'(byte_done), 0);
        chk("idle_msg_ready", int'(msg_ready), 1);
      end
    end
  end

  initial begin
    int a1, a2;
    logic [7:0] s;
    logic [7:0] picks[7];
    picks = '{8'h90, 8'h91, 8'hB0, 8'hC3, 8'hE0, 8'hF8, 8'hF0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    send(8'h90, 8'h3C, 8'h64, a1);
    send(8'h90, 8'h40, 8'h00, a2);
    chk("b2b_spacing", a2 - a1, 3 * FRAME);
    wait_idle();
    send(8'hC5, 8'h8A, 8'h55, a1);
    wait_idle();
    send(8'h90, 8'h11, 8'h22, a1);
    send(8'hF8, 8'h00, 8'h00, a1);
    send(8'h90, 8'h33, 8'h44, a1);
    wait_idle();
    send(8'h90, 8'h12, 8'h34, a1);
    send(8'hF0, 8'h00, 8'h00, a1);
    send(8'h90, 8'h56, 8'h78, a1);
    wait_idle();
    send(8'h3C, 8'h01, 8'h02, a1);
    repeat (3) @(posedge clk);
    #1;
    send(8'h90, 8'h3C, 8'h64, a1);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    last_rs = -1;
    drop_at = -1;
    #1;
    chk("reset_midframe_tx", int'(midi_tx), 1);
    chk("reset_midframe_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send(8'h90, 8'h3C, 8'h64, a1);
    wait_idle();
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0: s = 8'($urandom_range(0, 127));
        1, 2, 3: s = picks[$urandom_range(0, 6)];
        default: s = 8'($urandom_range(128, 255));
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(s, 8'($urandom), 8'($urandom), a1);
    end
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
